// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for a 5-stage pipeline. Detects load-use hazards and inserts
//   a single ID/EX bubble, squashes wrong-path instructions on a taken redirect, freezes the
//   front-end while a data-memory access waits (with a sticky timeout error), and keeps
//   saturating stall/flush performance counters.
//
// Ports
//   clk, rst_n       clock (rising edge), synchronous active-low reset
//   ID_*             source register indices / use flags of the instruction in ID
//   EX_*             destination, load flag and resolved redirect of the instruction in EX
//   MEM_req_i        MEM-stage instruction accesses dmem
//   MEM_ready_i      dmem completes the access this cycle
//   *_stall_o        hold PC / pipeline register (combinational)
//   *_flush_o        load NOP/bubble into pipeline register (combinational)
//   mem_timeout_o    sticky dmem timeout error
//   stall_cnt_o      saturating count of cycles with pc_stall_o=1
//   flush_cnt_o      saturating count of redirect flushes
// ---------------------------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned MAX_MEM_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] ID_rs1_i,
    input  logic [REG_ADDR_W-1:0] ID_rs2_i,
    input  logic                  ID_uses_rs1_i,
    input  logic                  ID_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] EX_rd_i,
    input  logic                  EX_MemRead_i,
    input  logic                  EX_redirect_i,
    input  logic                  MEM_req_i,
    input  logic                  MEM_ready_i,
    output logic                  pc_stall_o,
    output logic                  IF_ID_stall_o,
    output logic                  IF_ID_flush_o,
    output logic                  ID_EX_stall_o,
    output logic                  ID_EX_flush_o,
    output logic                  EX_MEM_stall_o,
    output logic                  mem_timeout_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam int unsigned WAIT_W = (MAX_MEM_WAIT < 1) ? 1 : $clog2(MAX_MEM_WAIT + 1);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StError   = 2'd2
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_cnt_nxt;
    logic                r_timeout;
    logic                w_timeout_nxt;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic                w_mem_wait;
    logic                w_load_use;
    logic                w_redirect_flush;

    assign w_mem_wait = MEM_req_i & ~MEM_ready_i;

    // x0 is hard-wired zero, so a load targeting it never creates a real dependency.
    assign w_load_use = EX_MemRead_i & (EX_rd_i != '0) &
                        ((ID_uses_rs1_i & (ID_rs1_i == EX_rd_i)) |
                         (ID_uses_rs2_i & (ID_rs2_i == EX_rd_i)));

    // Next-state logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout_nxt  = r_timeout;
        unique case (r_state)
            StRun: begin
                if (w_mem_wait) begin
                    w_state_nxt    = StMemWait;
                    w_wait_cnt_nxt = WAIT_W'(1);
                end
            end
            StMemWait: begin
                if (MEM_ready_i) begin
                    w_state_nxt    = StRun;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WAIT_W'(MAX_MEM_WAIT)) begin
                    w_state_nxt   = StError;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            StError: begin
                w_state_nxt = StError;
            end
            default: begin
                w_state_nxt = StRun;
            end
        endcase
    end

    // Mealy stall/flush outputs, highest priority first. All forced low while in reset.
    always_comb begin
        pc_stall_o       = 1'b0;
        IF_ID_stall_o    = 1'b0;
        IF_ID_flush_o    = 1'b0;
        ID_EX_stall_o    = 1'b0;
        ID_EX_flush_o    = 1'b0;
        EX_MEM_stall_o   = 1'b0;
        w_redirect_flush = 1'b0;
        if (rst_n) begin
            if ((r_state == StError) || w_mem_wait) begin
                // Freeze everything; a pending redirect keeps its inputs and fires later.
                pc_stall_o     = 1'b1;
                IF_ID_stall_o  = 1'b1;
                ID_EX_stall_o  = 1'b1;
                EX_MEM_stall_o = 1'b1;
            end else if (EX_redirect_i) begin
                // The ID instruction is wrong-path, so any load-use on it is irrelevant.
                w_redirect_flush = 1'b1;
                IF_ID_flush_o    = 1'b1;
                ID_EX_flush_o    = 1'b1;
            end else if (w_load_use) begin
                pc_stall_o    = 1'b1;
                IF_ID_stall_o = 1'b1;
                ID_EX_flush_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StRun;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
            if (pc_stall_o && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_redirect_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_timeout_o = r_timeout;
    assign stall_cnt_o   = r_stall_cnt;
    assign flush_cnt_o   = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Self-checking bench: a table of single-cycle vectors with hand-computed outputs, then
//   hand-written sequences for reset, load-use, redirect, memory wait, timeout and counter
//   saturation (second instance with a 4-bit counter).
// ---------------------------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_u1;
    logic       id_u2;
    logic [4:0] ex_rd;
    logic       ex_mr;
    logic       ex_redir;
    logic       mem_req;
    logic       mem_rdy;

    logic        pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, tmo;
    logic [31:0] scnt, fcnt;
    logic        pc_s2, ifid_s2, ifid_f2, idex_s2, idex_f2, exmem_s2, tmo2;
    logic [3:0]  scnt2, fcnt2;
    logic [5:0]  outs;

    assign outs = {pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s};

    pipeline_hazard_ctrl #(
        .REG_ADDR_W  (5),
        .CNT_W       (32),
        .MAX_MEM_WAIT(15)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ID_rs1_i      (id_rs1),
        .ID_rs2_i      (id_rs2),
        .ID_uses_rs1_i (id_u1),
        .ID_uses_rs2_i (id_u2),
        .EX_rd_i       (ex_rd),
        .EX_MemRead_i  (ex_mr),
        .EX_redirect_i (ex_redir),
        .MEM_req_i     (mem_req),
        .MEM_ready_i   (mem_rdy),
        .pc_stall_o    (pc_s),
        .IF_ID_stall_o (ifid_s),
        .IF_ID_flush_o (ifid_f),
        .ID_EX_stall_o (idex_s),
        .ID_EX_flush_o (idex_f),
        .EX_MEM_stall_o(exmem_s),
        .mem_timeout_o (tmo),
        .stall_cnt_o   (scnt),
        .flush_cnt_o   (fcnt)
    );

    pipeline_hazard_ctrl #(
        .REG_ADDR_W  (5),
        .CNT_W       (4),
        .MAX_MEM_WAIT(15)
    ) u_dut4 (
        .clk           (clk),
        .rst_n         (rst_n),
        .ID_rs1_i      (id_rs1),
        .ID_rs2_i      (id_rs2),
        .ID_uses_rs1_i (id_u1),
        .ID_uses_rs2_i (id_u2),
        .EX_rd_i       (ex_rd),
        .EX_MemRead_i  (ex_mr),
        .EX_redirect_i (ex_redir),
        .MEM_req_i     (mem_req),
        .MEM_ready_i   (mem_rdy),
        .pc_stall_o    (pc_s2),
        .IF_ID_stall_o (ifid_s2),
        .IF_ID_flush_o (ifid_f2),
        .ID_EX_stall_o (idex_s2),
        .ID_EX_flush_o (idex_f2),
        .EX_MEM_stall_o(exmem_s2),
        .mem_timeout_o (tmo2),
        .stall_cnt_o   (scnt2),
        .flush_cnt_o   (fcnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output order: {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
    // EX_MEM_stall}.
    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       redir;
        logic       req;
        logic       rdy;
        logic [5:0] exp;
    } vec_t;

    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_LU    = 6'b110010;
    localparam logic [5:0] O_FLUSH = 6'b001010;
    localparam logic [5:0] O_FRZ   = 6'b110101;

    vec_t tbl[13];
    int   checks;
    int   errors;
    int   exp_stall;
    int   exp_flush;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_rs1   = 5'd0;
        id_rs2   = 5'd0;
        id_u1    = 1'b0;
        id_u2    = 1'b0;
        ex_rd    = 5'd0;
        ex_mr    = 1'b0;
        ex_redir = 1'b0;
        mem_req  = 1'b0;
        mem_rdy  = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        id_rs1   = v.rs1;
        id_rs2   = v.rs2;
        id_u1    = v.u1;
        id_u2    = v.u2;
        ex_rd    = v.rd;
        ex_mr    = v.mr;
        ex_redir = v.redir;
        mem_req  = v.req;
        mem_rdy  = v.rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //              rs1    rs2    u1    u2    rd     mr    redir req   rdy   exp
        tbl[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
        tbl[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        tbl[2]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE};
        tbl[3]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE};
        tbl[4]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
        tbl[5]  = '{5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        tbl[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_FLUSH};
        tbl[7]  = '{5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, O_FLUSH};
        tbl[8]  = '{5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, O_LU};
        tbl[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ};
        tbl[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_FRZ};
        tbl[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, O_FLUSH};
        tbl[12] = '{5'd0, 5'd4, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};

        // Reset with every input active: outputs forced low, registers cleared.
        rst_n = 1'b0;
        id_rs1 = 5'd5; id_rs2 = 5'd5; id_u1 = 1'b1; id_u2 = 1'b1; ex_rd = 5'd5;
        ex_mr = 1'b1; ex_redir = 1'b1; mem_req = 1'b1; mem_rdy = 1'b0;
        @(negedge clk);
        #2 chk("reset_outs", 32'(outs), 32'(O_NONE));
        @(negedge clk);
        chk("reset_outs2", 32'(outs), 32'(O_NONE));
        chk("reset_stall_cnt", scnt, 32'd0);
        chk("reset_flush_cnt", fcnt, 32'd0);
        chk("reset_timeout", 32'(tmo), 32'd0);
        idle();
        rst_n = 1'b1;
        #2 chk("post_reset_idle", 32'(outs), 32'(O_NONE));

        // Table-driven vectors.
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            apply(tbl[i]);
            #2 chk($sformatf("vec%0d", i), 32'(outs), 32'(tbl[i].exp));
            exp_stall += int'(tbl[i].exp[5]);
            exp_flush += (tbl[i].exp == O_FLUSH) ? 1 : 0;
        end
        @(negedge clk);
        idle();
        chk("tbl_stall_cnt", scnt, 32'(exp_stall));
        chk("tbl_flush_cnt", fcnt, 32'(exp_flush));

        // Load-use: exactly one bubble; rd=0 never stalls.
        do_reset();
        ex_mr = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_u2 = 1'b1;
        #2 chk("lu_bubble", 32'(outs), 32'(O_LU));
        @(negedge clk);
        ex_mr = 1'b0;
        #2 chk("lu_moved", 32'(outs), 32'(O_NONE));
        chk("lu_stall_cnt", scnt, 32'd1);
        @(negedge clk);
        ex_mr = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        #2 chk("lu_rd0", 32'(outs), 32'(O_NONE));
        @(negedge clk);
        idle();
        chk("lu_rd0_cnt", scnt, 32'd1);

        // Redirect overrides load-use.
        do_reset();
        ex_mr = 1'b1; ex_rd = 5'd6; id_rs1 = 5'd6; id_u1 = 1'b1; ex_redir = 1'b1;
        #2 chk("redir_over_lu", 32'(outs), 32'(O_FLUSH));
        @(negedge clk);
        idle();
        chk("redir_flush_cnt", fcnt, 32'd1);
        chk("redir_stall_cnt", scnt, 32'd0);

        // Memory wait for 3 cycles then ready.
        do_reset();
        mem_req = 1'b1; mem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2 chk($sformatf("mw_freeze%0d", i), 32'(outs), 32'(O_FRZ));
            @(negedge clk);
        end
        mem_rdy = 1'b1;
        #2 chk("mw_ready", 32'(outs), 32'(O_NONE));
        @(negedge clk);
        idle();
        chk("mw_stall_cnt", scnt, 32'd3);
        chk("mw_no_timeout", 32'(tmo), 32'd0);

        // Timeout: error after the 16th wait cycle, sticky until reset.
        do_reset();
        mem_req = 1'b1; mem_rdy = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 15) chk("tmo_before", 32'(tmo), 32'd0);
            if (i == 16) chk("tmo_rise", 32'(tmo), 32'd1);
        end
        chk("tmo_held", 32'(tmo), 32'd1);
        idle();
        #2 chk("err_freeze", 32'(outs), 32'(O_FRZ));
        ex_redir = 1'b1;
        #1 chk("err_no_flush", 32'(outs), 32'(O_FRZ));
        @(negedge clk);
        chk("err_sticky", 32'(tmo), 32'd1);
        do_reset();
        #2 chk("err_cleared", 32'(tmo), 32'd0);
        chk("err_outs_cleared", 32'(outs), 32'(O_NONE));

        // Counter saturation on the 4-bit build.
        do_reset();
        ex_mr = 1'b1; ex_rd = 5'd2; id_rs1 = 5'd2; id_u1 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 14) chk("sat_14", 32'(scnt2), 32'd14);
            if (i == 15) chk("sat_15", 32'(scnt2), 32'd15);
            if (i == 16) chk("sat_hold16", 32'(scnt2), 32'd15);
        end
        chk("sat_hold20", 32'(scnt2), 32'd15);
        chk("wide_cnt20", scnt, 32'd20);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
